// File: rtl/alu_op_sequencer.sv
// Multicycle R-type ALU sequencer: drives a shared ALU, iterates shifts one bit per cycle, applies SLT fix-up.
// Build option: define ALU_SEQ_VAR_SHIFT_EN to accept SLLV/SRLV (amount taken from op_a[4:0]).
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_select,
  output logic             alu_c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_SHIFT, ST_DONE} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] ra_r, ra_s, rb_r, rb_s, result_r, result_s;
  logic [5:0]       funct_r, funct_s;
  logic [4:0]       cnt_r, cnt_s;
  logic [4:0]       sel_r, sel_s;
  logic             cin_r, cin_s;
  logic             illegal_r, illegal_s, done_r, done_s, busy_r, busy_s;
  logic [4:0]       amt_s;
  logic             ovf_s, lt_s;

  // {select, c_in} driven while an operation sits in EXEC.
  function automatic logic [5:0] exec_code(input logic [5:0] f);
    case (f)
      F_ADD, F_ADDU: exec_code = 6'b00001_0;
      F_SUB, F_SUBU: exec_code = 6'b00010_1;
      F_AND:         exec_code = 6'b00100_0;
      F_OR:          exec_code = 6'b00101_0;
      F_XOR:         exec_code = 6'b00110_0;
      F_NOR:         exec_code = 6'b00101_1;
      F_SLT:         exec_code = 6'b00010_1;
      F_SLL, F_SRL:  exec_code = 6'b00011_1;
`ifdef ALU_SEQ_VAR_SHIFT_EN
      F_SLLV, F_SRLV: exec_code = 6'b00011_1;
`endif
      default:       exec_code = 6'b00000_0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] f);
    case (f)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT,
      F_SLL, F_SRL: is_legal = 1'b1;
`ifdef ALU_SEQ_VAR_SHIFT_EN
      F_SLLV, F_SRLV: is_legal = 1'b1;
`endif
      default:      is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL: is_shift = 1'b1;
`ifdef ALU_SEQ_VAR_SHIFT_EN
      F_SLLV, F_SRLV: is_shift = 1'b1;
`endif
      default:      is_shift = 1'b0;
    endcase
  endfunction

  function automatic logic is_left(input logic [5:0] f);
    case (f)
      F_SLL:   is_left = 1'b1;
`ifdef ALU_SEQ_VAR_SHIFT_EN
      F_SLLV:  is_left = 1'b1;
`endif
      default: is_left = 1'b0;
    endcase
  endfunction

  // Shift amount source: variable shifts take it from rs, fixed shifts from shamt.
  always_comb begin
    amt_s = shamt;
`ifdef ALU_SEQ_VAR_SHIFT_EN
    if (funct == F_SLLV || funct == F_SRLV) begin
      amt_s = op_a[4:0];
    end else begin
      amt_s = shamt;
    end
`endif
  end

  // SLT: signed less-than recovered from the subtract result and its overflow.
  assign ovf_s = (ra_r[WIDTH-1] != rb_r[WIDTH-1]) && (alu_y[WIDTH-1] != ra_r[WIDTH-1]);
  assign lt_s  = alu_y[WIDTH-1] ^ ovf_s;

  // Next-state, datapath-register and registered-output decode.
  always_comb begin
    state_s   = state_r;
    ra_s      = ra_r;
    rb_s      = rb_r;
    funct_s   = funct_r;
    cnt_s     = cnt_r;
    result_s  = result_r;
    illegal_s = illegal_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          funct_s = funct;
          ra_s    = op_a;
          rb_s    = op_b;
          if (is_shift(funct) && (amt_s != 5'd0)) begin
            ra_s    = op_b;
            cnt_s   = amt_s;
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_s = ST_DONE;
        if (!is_legal(funct_r)) begin
          illegal_s = 1'b1;
          result_s  = '0;
        end else if (funct_r == F_SLT) begin
          illegal_s = 1'b0;
          result_s  = {{(WIDTH-1){1'b0}}, lt_s};
        end else begin
          illegal_s = 1'b0;
          result_s  = alu_y;
        end
      end
      ST_SHIFT: begin
        ra_s  = alu_y;
        cnt_s = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          result_s  = alu_y;
          illegal_s = 1'b0;
          state_s   = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    done_s = (state_s == ST_DONE);
    busy_s = (state_s != ST_IDLE);
    case (state_s)
      ST_EXEC: {sel_s, cin_s} = exec_code(funct_s);
      ST_SHIFT: begin
        if (is_left(funct_s)) begin
          {sel_s, cin_s} = 6'b01000_0;
        end else begin
          {sel_s, cin_s} = 6'b10000_0;
        end
      end
      default: {sel_s, cin_s} = 6'b00000_0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ra_r      <= '0;
      rb_r      <= '0;
      funct_r   <= 6'd0;
      cnt_r     <= 5'd0;
      result_r  <= '0;
      illegal_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      sel_r     <= 5'd0;
      cin_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      ra_r      <= ra_s;
      rb_r      <= rb_s;
      funct_r   <= funct_s;
      cnt_r     <= cnt_s;
      result_r  <= result_s;
      illegal_r <= illegal_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
      sel_r     <= sel_s;
      cin_r     <= cin_s;
    end
  end

  assign alu_a      = ra_r;
  assign alu_b      = rb_r;
  assign alu_select = sel_r;
  assign alu_c_in   = cin_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = result_r;
  assign illegal    = illegal_r;

endmodule
